int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_pkg.sv | 58 +++++
 rtl/nmi_edge.sv | 32 +++
 rtl/int_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared encodings for the interrupt sequencer: sequencer states, interrupt kinds, vectors.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package int_pkg;

    // One state per bus cycle of the 7-cycle interrupt entry sequence, plus IDLE
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DMY1 = 3'd1,
        ST_DMY2 = 3'd2,
        ST_PCH  = 3'd3,
        ST_PCL  = 3'd4,
        ST_PSW  = 3'd5,
        ST_VLO  = 3'd6,
        ST_VHI  = 3'd7
    } state_t;

    // Interrupt kind as seen on the kind output
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_RES  = 2'd1,
        KIND_NMI  = 2'd2,
        KIND_IRQ  = 2'd3
    } kind_t;

    localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
    localparam logic [15:0] VEC_NMI_HI = 16'hFFFB;
    localparam logic [15:0] VEC_RES_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RES_HI = 16'hFFFD;
    localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;
    localparam logic [15:0] VEC_IRQ_HI = 16'hFFFF;

    localparam logic [7:0] STACK_PAGE = 8'h01;
    localparam logic [7:0] PSW_B      = 8'h10;
    localparam logic [7:0] PSW_U      = 8'h20;

    function automatic logic [15:0] vec_lo(input kind_t k);
        case (k)
            KIND_NMI: return VEC_NMI_LO;
            KIND_RES: return VEC_RES_LO;
            default:  return VEC_IRQ_LO;
        endcase
    endfunction

    function automatic logic [15:0] vec_hi(input kind_t k);
        case (k)
            KIND_NMI: return VEC_NMI_HI;
            KIND_RES: return VEC_RES_HI;
            default:  return VEC_IRQ_HI;
        endcase
    endfunction

    // Status byte as pushed: unused bit 5 always 1, bit 4 tells BRK from hardware IRQ
    function automatic logic [7:0] psw_push(input logic [7:0] p, input logic brk);
        return (p & ~PSW_B) | PSW_U | (brk ? PSW_B : 8'h00);
    endfunction

endpackage

// File: rtl/nmi_edge.sv
// NMI falling-edge detector with sticky pending flag, cleared when the NMI vector is fetched.
// Latency: fall is combinational against the previous sample; pend rises one clock after the edge.
// Backpressure: none; a new edge in the same cycle as clr wins so no NMI is lost.
module nmi_edge (
    input  logic clk,
    input  logic rst,
    input  logic nmi_n,
    input  logic clr,
    output logic fall,
    output logic pend
);

    logic nmi_prev;

    assign fall = nmi_prev && !nmi_n;

    // Track previous pin level and hold the pending flag until serviced
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_prev <= 1'b1;
            pend     <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            if (fall) begin
                pend <= 1'b1;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// 6502-style interrupt entry sequencer: RES/NMI/IRQ/BRK push PC and P, then fetch the vector.
// Latency: 7 busy cycles from DMY1 to VHI; pc_load/set_i pulse in VHI.
// Backpressure: rdy=0 freezes the sequencer and its outputs with we forced low; res_n=0 aborts.
module int_ctrl
    import int_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        res_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        sync,
    input  logic        rdy,
    input  logic        brk_req,
    input  logic        i_flag,
    input  logic [15:0] pc,
    input  logic [7:0]  p,
    input  logic [7:0]  sp,
    input  logic [7:0]  din,
    output logic        busy,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        sp_dec,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        set_i,
    output logic [1:0]  kind
);

    state_t     state;
    state_t     state_nxt;
    kind_t      kind_q;
    kind_t      kind_nxt;
    logic       brk_q;
    logic       brk_nxt;
    logic [7:0] latched_lo;
    logic       res_pend;
    logic       nmi_fall;
    logic       nmi_pend;
    logic       nmi_clr;
    logic       irq_act;

    // IRQ is a level request, masked by P.I and never latched
    assign irq_act = !irq_n && !i_flag;

    // NMI is consumed only when its vector low byte is actually fetched
    assign nmi_clr = (state == ST_VLO) && (kind_q == KIND_NMI) && rdy && res_n;

    assign kind = kind_q;

    nmi_edge u_nmi_edge (
        .clk   (clk),
        .rst   (rst),
        .nmi_n (nmi_n),
        .clr   (nmi_clr),
        .fall  (nmi_fall),
        .pend  (nmi_pend)
    );

    // State register plus sequence context (kind, BRK flag, vector low byte, reset pending)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            kind_q     <= KIND_NONE;
            brk_q      <= 1'b0;
            latched_lo <= 8'h00;
            res_pend   <= 1'b1;
        end else begin
            state  <= state_nxt;
            kind_q <= kind_nxt;
            brk_q  <= brk_nxt;
            if ((state == ST_VLO) && rdy && res_n) begin
                latched_lo <= din;
            end
            if (!res_n) begin
                res_pend <= 1'b1;
            end else if ((state == ST_VHI) && (kind_q == KIND_RES) && rdy) begin
                res_pend <= 1'b0;
            end
        end
    end

    // Next state: reset pin aborts any sequence, otherwise advance one step per rdy cycle
    always_comb begin
        state_nxt = state;
        kind_nxt  = kind_q;
        brk_nxt   = brk_q;
        if ((state != ST_IDLE) && !res_n) begin
            state_nxt = ST_IDLE;
            kind_nxt  = KIND_NONE;
            brk_nxt   = 1'b0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (res_pend || !res_n) begin
                        // A pending reset blocks NMI/IRQ and waits for the pin to release
                        if (res_n) begin
                            state_nxt = ST_DMY1;
                            kind_nxt  = KIND_RES;
                            brk_nxt   = 1'b0;
                        end
                    end else if (sync && (nmi_pend || irq_act || brk_req)) begin
                        state_nxt = ST_DMY1;
                        kind_nxt  = nmi_pend ? KIND_NMI : KIND_IRQ;
                        // Hardware IRQ at the same boundary pre-empts BRK, so B=0
                        brk_nxt   = !nmi_pend && !irq_act && brk_req;
                    end
                end
                ST_DMY1: state_nxt = ST_DMY2;
                ST_DMY2: state_nxt = ST_PCH;
                ST_PCH:  state_nxt = ST_PCL;
                ST_PCL:  state_nxt = ST_PSW;
                ST_PSW: begin
                    state_nxt = ST_VLO;
                    // NMI arriving during an IRQ/BRK push steals the vector fetch
                    if ((kind_q == KIND_IRQ) && (nmi_pend || nmi_fall)) begin
                        kind_nxt = KIND_NMI;
                    end
                end
                ST_VLO:  state_nxt = ST_VHI;
                ST_VHI: begin
                    state_nxt = ST_IDLE;
                    kind_nxt  = KIND_NONE;
                    brk_nxt   = 1'b0;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Bus and strobe outputs decoded from the current state; all quiet while rst is high
    always_comb begin
        busy    = 1'b0;
        addr    = 16'h0000;
        dout    = 8'h00;
        we      = 1'b0;
        sp_dec  = 1'b0;
        pc_load = 1'b0;
        pc_new  = 16'h0000;
        set_i   = 1'b0;
        if (!rst) begin
            case (state)
                ST_DMY1, ST_DMY2: begin
                    busy = 1'b1;
                    addr = pc;
                end
                ST_PCH, ST_PCL, ST_PSW: begin
                    busy   = 1'b1;
                    addr   = {STACK_PAGE, sp};
                    sp_dec = 1'b1;
                    // Reset runs the push cycles as reads so memory is untouched
                    we     = rdy && (kind_q != KIND_RES);
                    if (state == ST_PCH) begin
                        dout = pc[15:8];
                    end else if (state == ST_PCL) begin
                        dout = pc[7:0];
                    end else begin
                        dout = psw_push(p, brk_q);
                    end
                end
                ST_VLO: begin
                    busy = 1'b1;
                    addr = vec_lo(kind_q);
                end
                ST_VHI: begin
                    busy    = 1'b1;
                    addr    = vec_hi(kind_q);
                    pc_load = 1'b1;
                    pc_new  = {din, latched_lo};
                    set_i   = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule
